dfx_shutdown_seq: RTL and testbench
===================================

# dfx_shutdown_seq

Sequencer that drives a safe partial-reconfiguration cycle for the LED reconfigurable modules. It sits directly upstream of `dfx_axi_mgr`: it raises `request_shutdown` and waits for `in_shutdown`, then decouples and resets the reconfigurable partitions around the bitstream load. It releases the AXI manager afterwards. Status outputs are exposed for the register block and the ILA.

## Interface
Parameters:
- `SHUTDOWN_TIMEOUT`, 1024 — maximum cycles to wait for `in_shutdown_i` after the request is raised.
- `PR_TIMEOUT`, 1000000 — maximum cycles to wait for `pr_done_i` (10 ms at 100 MHz).
- `RM_RST_CYCLES`, 16 — length of the reconfigurable-module reset pulse; minimum 1.

Ports:
- `clk100`  in  1  — single clock; 100 MHz.
- `rst`  in  1  — synchronous reset, active-high.
- `dfx_start_i`  in  1  — reconfiguration request (level); a rising edge starts a cycle.
- `in_shutdown_i`  in  1  — from `dfx_axi_mgr` `in_shutdown`.
- `pr_done_i`  in  1  — single-cycle pulse from the PR controller when the bitstream load completes.
- `clear_err_i`  in  1  — single-cycle pulse that leaves the error state.
- `request_shutdown_o`  out  1  — to `dfx_axi_mgr` `request_shutdown`.
- `decouple_o`  out  1  — gates the reconfigurable-module outputs (the LED muxes).
- `rm_reset_o`  out  1  — active-high reset to the `led_cnt*_pr` partitions.
- `busy_o`  out  1  — high in every state except IDLE.
- `done_o`  out  1  — one-cycle pulse when a cycle completes.
- `error_o`  out  1  — high in ERR.
- `reconfig_cnt_o`  out  8  — count of completed cycles; wraps 255→0.

## Operation
- The state machine is Moore. All outputs are registered and valid in the same cycle the state register holds the state.
- Start detect: `start_q` is a registered copy of `dfx_start_i` and resets to 1. A start edge is `dfx_start_i & ~start_q`. A level held high through reset does not trigger; it must drop low and rise again.

States:
- **IDLE**: all outputs 0.
  - Start edge → REQ.
- **REQ**: `request_shutdown_o`=1. The timer counts from 0.
  - `in_shutdown_i`=1 → DECOUPLE.
  - Timer = `SHUTDOWN_TIMEOUT`-1 with `in_shutdown_i`=0 → ERR.
  - If `in_shutdown_i` and the timeout occur in the same cycle, `in_shutdown_i` wins.
- **DECOUPLE**: `request_shutdown_o`=1, `decouple_o`=1; lasts exactly 1 cycle → WAIT_PR. The timer clears.
- **WAIT_PR**: `request_shutdown_o`=1, `decouple_o`=1.
  - `pr_done_i` → RM_RST.
  - Timer = `PR_TIMEOUT`-1 without `pr_done_i` → ERR. `pr_done_i` wins on a tie.
- **RM_RST**: `request_shutdown_o`=1, `decouple_o`=1, `rm_reset_o`=1; lasts exactly `RM_RST_CYCLES` cycles → RELEASE.
- **RELEASE**: `request_shutdown_o`=0, `decouple_o`=0, `rm_reset_o`=0.
  - `in_shutdown_i`=0 → IDLE. On this transition `done_o` pulses for 1 cycle (the first IDLE cycle) and `reconfig_cnt_o` increments.
  - No timeout applies in RELEASE.
- **ERR**: `error_o`=1, `decouple_o`=1, `rm_reset_o`=1, `request_shutdown_o`=0.
  - `clear_err_i` → IDLE with all outputs 0.
  - `reconfig_cnt_o` is unchanged.

Ignored inputs:
- Start edges outside IDLE are dropped, not queued.
- `pr_done_i` outside WAIT_PR is ignored.
- `clear_err_i` outside ERR is ignored.

Timer:
- Single counter of width `$clog2(max(PR_TIMEOUT, SHUTDOWN_TIMEOUT, RM_RST_CYCLES)+1)`.
- Cleared on every state change; it never wraps within a state.

## Timing
- Reset values:
  - State IDLE; timer 0; `start_q`=1.
  - `request_shutdown_o`, `decouple_o`, `rm_reset_o`, `busy_o`, `done_o`, `error_o` all 0.
  - `reconfig_cnt_o`=0.
- Reset mid-operation: next cycle is IDLE with all outputs 0, including deasserting `decouple_o`/`rm_reset_o` from ERR or RM_RST.
- Start latency: edge sampled at cycle N → `request_shutdown_o`=1 and `busy_o`=1 at N+1.
- `in_shutdown_i` seen at cycle M in REQ → `decouple_o`=1 at M+1; WAIT_PR at M+2.
- `pr_done_i` at cycle P → `rm_reset_o` high for cycles P+1 … P+`RM_RST_CYCLES`; RELEASE at P+`RM_RST_CYCLES`+1.
- Minimum full cycle, with `in_shutdown_i` immediate and `pr_done_i` the first WAIT_PR cycle: `RM_RST_CYCLES`+5 cycles from the start edge to `done_o`.

## Configuration
- Macro `DFX_SEQ_TIMEOUT_EN`.
- Defined: the REQ and WAIT_PR timeouts and the ERR state are implemented as above.
- Undefined:
  - No timeout transitions; REQ and WAIT_PR wait indefinitely.
  - ERR is unreachable; `error_o` is tied 0 and `clear_err_i` is unused.
  - The timer exists only for RM_RST, sized `$clog2(RM_RST_CYCLES+1)`.

## Test plan
- **Nominal cycle**: `RM_RST_CYCLES`=16. Start edge; `in_shutdown_i` asserted 3 cycles later; `pr_done_i` 50 cycles later; `in_shutdown_i` dropped 2 cycles after RELEASE.
  - Expect `rm_reset_o` high for exactly 16 cycles.
  - Expect one `done_o` pulse and `reconfig_cnt_o`=1.
- **Shutdown timeout** (macro defined, `SHUTDOWN_TIMEOUT`=1024): start edge, `in_shutdown_i` never asserted.
  - Expect `error_o`=1 exactly 1024 cycles after REQ entry, with `decouple_o`=1 and `rm_reset_o`=1.
  - `clear_err_i` → all outputs 0 next cycle; `reconfig_cnt_o` still 0.
- **Tie cases**:
  - `in_shutdown_i` rising on REQ timer=1023 → DECOUPLE, not ERR.
  - `pr_done_i` on the final WAIT_PR cycle → RM_RST.
- **Ignored inputs**:
  - Second start edge during WAIT_PR and `pr_done_i` during REQ are both ignored.
  - Only one `done_o` and count +1.
- **Reset behaviour**:
  - `dfx_start_i` held high through `rst` release → no cycle starts; a low→high afterwards starts one.
  - `rst` asserted mid-RM_RST → all outputs 0 the next cycle.
- **Wrap**: 256 nominal cycles with small `PR_TIMEOUT`/`RM_RST_CYCLES` → `reconfig_cnt_o` returns to 0.

Source files
------------

// File: rtl/dfx_shutdown_seq_if.sv
// -----------------------------------------------------------------------------
// dfx_shutdown_seq_if
// Shutdown handshake between the DFX sequencer and dfx_axi_mgr.
//
// Signals:
//   request_shutdown - sequencer asks the AXI manager to quiesce its traffic
//   in_shutdown      - AXI manager reports that it is quiesced
//
// Modports:
//   master - sequencer side (drives request_shutdown, observes in_shutdown)
//   slave  - AXI manager side (observes request_shutdown, drives in_shutdown)
// -----------------------------------------------------------------------------
interface dfx_shutdown_seq_if;
  logic request_shutdown;
  logic in_shutdown;

  modport master (output request_shutdown, input in_shutdown);
  modport slave  (input request_shutdown, output in_shutdown);
endinterface

// File: rtl/dfx_shutdown_seq.sv
// -----------------------------------------------------------------------------
// dfx_shutdown_seq
// Drives a safe partial-reconfiguration cycle for the LED reconfigurable
// modules: quiesce the AXI manager, decouple the partitions, wait for the
// bitstream load, pulse the partition reset, then release the AXI manager.
//
// Optional feature macro: DFX_SEQ_TIMEOUT_EN
//   defined   - REQ and WAIT_PR time out into ERR; clear_err_i leaves ERR
//   undefined - REQ and WAIT_PR wait forever; ERR unreachable, error_o = 0
//
// Ports:
//   clk100          in   100 MHz clock
//   rst             in   synchronous active-high reset
//   dfx_start_i     in   reconfiguration request level (rising edge starts)
//   pr_done_i       in   one-cycle pulse when the bitstream load completes
//   clear_err_i     in   one-cycle pulse that leaves ERR
//   shut_if         if   shutdown handshake with dfx_axi_mgr (master side)
//   decouple_o      out  gates the reconfigurable-module outputs
//   rm_reset_o      out  active-high reset to the led_cnt*_pr partitions
//   busy_o          out  high whenever the sequencer is not idle
//   done_o          out  one-cycle pulse when a cycle completes
//   error_o         out  high while in ERR
//   reconfig_cnt_o  out  completed-cycle counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module dfx_shutdown_seq #(
  parameter int SHUTDOWN_TIMEOUT = 1024,
  parameter int PR_TIMEOUT       = 1000000,
  parameter int RM_RST_CYCLES    = 16
) (
  input  logic                   clk100,
  input  logic                   rst,
  input  logic                   dfx_start_i,
  input  logic                   pr_done_i,
  input  logic                   clear_err_i,
  dfx_shutdown_seq_if.master     shut_if,
  output logic                   decouple_o,
  output logic                   rm_reset_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [7:0]             reconfig_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DECOUPLE,
    S_WAIT_PR,
    S_RM_RST,
    S_RELEASE,
    S_ERR
  } state_t;

`ifdef DFX_SEQ_TIMEOUT_EN
  localparam int TIMER_MAX =
    (PR_TIMEOUT > SHUTDOWN_TIMEOUT)
      ? ((PR_TIMEOUT > RM_RST_CYCLES) ? PR_TIMEOUT : RM_RST_CYCLES)
      : ((SHUTDOWN_TIMEOUT > RM_RST_CYCLES) ? SHUTDOWN_TIMEOUT : RM_RST_CYCLES);
`else
  localparam int TIMER_MAX = RM_RST_CYCLES;
`endif
  localparam int TW = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] RM_LAST = TW'(RM_RST_CYCLES - 1);
`ifdef DFX_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] SHUT_LAST = TW'(SHUTDOWN_TIMEOUT - 1);
  localparam logic [TW-1:0] PR_LAST   = TW'(PR_TIMEOUT - 1);
`endif

  state_t          r_state;
  state_t          w_nextState;
  logic [TW-1:0]   r_timer;
  logic            r_startQ;
  logic            r_requestShutdown;
  logic            r_decouple;
  logic            r_rmReset;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_reconfigCnt;
  logic            w_startEdge;
  logic            w_timerRun;
  logic            w_done;

  // r_startQ resets to 1 so a request held high through reset is not an edge.
  assign w_startEdge = dfx_start_i & ~r_startQ;
  assign w_done      = (r_state == S_RELEASE) && (w_nextState == S_IDLE);

`ifdef DFX_SEQ_TIMEOUT_EN
  assign w_timerRun = (r_state == S_REQ) || (r_state == S_WAIT_PR) ||
                      (r_state == S_RM_RST);
`else
  assign w_timerRun = (r_state == S_RM_RST);
`endif

  // Next-state logic; the handshake input is tested before the timeout so
  // that it wins a same-cycle tie.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (w_startEdge) w_nextState = S_REQ;
      S_REQ: begin
        if (shut_if.in_shutdown) w_nextState = S_DECOUPLE;
`ifdef DFX_SEQ_TIMEOUT_EN
        else if (r_timer == SHUT_LAST) w_nextState = S_ERR;
`endif
      end
      S_DECOUPLE: w_nextState = S_WAIT_PR;
      S_WAIT_PR: begin
        if (pr_done_i) w_nextState = S_RM_RST;
`ifdef DFX_SEQ_TIMEOUT_EN
        else if (r_timer == PR_LAST) w_nextState = S_ERR;
`endif
      end
      S_RM_RST:   if (r_timer == RM_LAST) w_nextState = S_RELEASE;
      S_RELEASE:  if (!shut_if.in_shutdown) w_nextState = S_IDLE;
      S_ERR: begin
`ifdef DFX_SEQ_TIMEOUT_EN
        if (clear_err_i) w_nextState = S_IDLE;
`endif
      end
      default:    w_nextState = S_IDLE;
    endcase
  end

  // State, timer and Moore outputs are registered together; outputs are
  // decoded from the next state so they line up with the state register.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_timer           <= '0;
      r_startQ          <= 1'b1;
      r_requestShutdown <= 1'b0;
      r_decouple        <= 1'b0;
      r_rmReset         <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_reconfigCnt     <= 8'd0;
    end else begin
      r_state  <= w_nextState;
      r_startQ <= dfx_start_i;
      if (w_nextState != r_state)
        r_timer <= '0;
      else if (w_timerRun)
        r_timer <= r_timer + 1'b1;
      r_requestShutdown <= (w_nextState == S_REQ) || (w_nextState == S_DECOUPLE) ||
                           (w_nextState == S_WAIT_PR) || (w_nextState == S_RM_RST);
      r_decouple        <= (w_nextState == S_DECOUPLE) || (w_nextState == S_WAIT_PR) ||
                           (w_nextState == S_RM_RST) || (w_nextState == S_ERR);
      r_rmReset         <= (w_nextState == S_RM_RST) || (w_nextState == S_ERR);
      r_busy            <= (w_nextState != S_IDLE);
      r_done            <= w_done;
      if (w_done)
        r_reconfigCnt <= r_reconfigCnt + 8'd1;
    end
  end

`ifdef DFX_SEQ_TIMEOUT_EN
  logic r_error;

  always_ff @(posedge clk100) begin
    if (rst) r_error <= 1'b0;
    else     r_error <= (w_nextState == S_ERR);
  end

  assign error_o = r_error;
`else
  // Timeouts are compiled out, so these inputs/parameters have no effect.
  logic w_unusedCfg;
  assign w_unusedCfg = clear_err_i ^ (SHUTDOWN_TIMEOUT != PR_TIMEOUT);
  assign error_o     = 1'b0;
`endif

  assign shut_if.request_shutdown = r_requestShutdown;
  assign decouple_o               = r_decouple;
  assign rm_reset_o               = r_rmReset;
  assign busy_o                   = r_busy;
  assign done_o                   = r_done;
  assign reconfig_cnt_o           = r_reconfigCnt;

endmodule

// File: tb/tb_dfx_shutdown_seq.sv
// -----------------------------------------------------------------------------
// tb_dfx_shutdown_seq
// Randomised bench for dfx_shutdown_seq. Each reconfiguration cycle is
// planned as a set of edge numbers (start, in_shutdown, pr_done, release);
// the expected completion edge and counter value follow from the latency
// rules and are queued. A monitor pops and compares whenever done_o pulses
// or error_o rises.
// -----------------------------------------------------------------------------
module tb_dfx_shutdown_seq;

  localparam int SHUT_T = 1024;
  localparam int PR_T   = 64;
  localparam int RMR    = 16;

  logic       clk100 = 1'b0;
  logic       rst = 1'b1;
  logic       dfx_start_i = 1'b0;
  logic       pr_done_i = 1'b0;
  logic       clear_err_i = 1'b0;
  logic       decouple_o, rm_reset_o, busy_o, done_o, error_o;
  logic [7:0] reconfig_cnt_o;

  dfx_shutdown_seq_if shutIf ();

  dfx_shutdown_seq #(
    .SHUTDOWN_TIMEOUT(SHUT_T),
    .PR_TIMEOUT(PR_T),
    .RM_RST_CYCLES(RMR)
  ) dut (
    .clk100(clk100),
    .rst(rst),
    .dfx_start_i(dfx_start_i),
    .pr_done_i(pr_done_i),
    .clear_err_i(clear_err_i),
    .shut_if(shutIf.master),
    .decouple_o(decouple_o),
    .rm_reset_o(rm_reset_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .reconfig_cnt_o(reconfig_cnt_o)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    int kind;     // 0 = done pulse, 1 = error entry
    int edgeIdx;  // clock edge after which the event is visible
    int cnt;      // expected reconfig_cnt_o at that point
  } event_t;

  event_t sbQ[$];
  event_t monEv;
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  int     modelCnt = 0;
  int     rmHigh = 0;
  logic   prevErr = 1'b0;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk100) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive inputs for the next edge, then move just past it.
  task automatic applyStimulus(input logic start, input logic shut,
                               input logic pr, input logic clr);
    dfx_start_i         = start;
    shutIf.in_shutdown  = shut;
    pr_done_i           = pr;
    clear_err_i         = clr;
    @(posedge clk100);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One full cycle. a: extra REQ cycles before in_shutdown, b: WAIT_PR cycles
  // before pr_done, c: RELEASE cycles before in_shutdown drops. noise adds a
  // pr_done during REQ and a start edge during WAIT_PR (needs b >= 1).
  task automatic runCycle(input int a, input int b, input int c, input bit noise);
    int n, m, p, q, e;
    event_t ev;
    n = cyc + 1;
    m = n + 1 + a;
    p = m + 2 + b;
    q = p + RMR + 1 + c;
    modelCnt = (modelCnt + 1) % 256;
    ev.kind = 0; ev.edgeIdx = q; ev.cnt = modelCnt;
    sbQ.push_back(ev);
    while (cyc < q) begin
      e = cyc + 1;
      applyStimulus((e == n) || (noise && e == p - 1),
                    (e >= m) && (e < q),
                    (e == p) || (noise && e == n + 1),
                    1'b0);
    end
  endtask

`ifdef DFX_SEQ_TIMEOUT_EN
  // Let REQ (prPhase=0) or WAIT_PR (prPhase=1) time out, then clear ERR.
  task automatic runTimeout(input bit prPhase);
    int n, eErr, e;
    event_t ev;
    n = cyc + 1;
    eErr = prPhase ? (n + 2 + PR_T) : (n + SHUT_T);
    ev.kind = 1; ev.edgeIdx = eErr; ev.cnt = modelCnt;
    sbQ.push_back(ev);
    while (cyc < eErr) begin
      e = cyc + 1;
      applyStimulus(e == n, prPhase && (e > n), 1'b0, 1'b0);
    end
    idle(3);
    checkOutput("error held", error_o, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("outputs after clear",
                {shutIf.request_shutdown, decouple_o, rm_reset_o, busy_o, done_o, error_o}, 0);
    checkOutput("count after clear", reconfig_cnt_o, modelCnt);
    idle(2);
  endtask
`endif

  // Monitor: compare each done pulse or error entry against the queue.
  always @(negedge clk100) begin
    if (rm_reset_o) rmHigh++;
    if (done_o || (error_o && !prevErr)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected event", 1, 0);
      end else begin
        monEv = sbQ.pop_front();
        checkOutput("event kind", done_o ? 0 : 1, monEv.kind);
        checkOutput("event edge", cyc, monEv.edgeIdx);
        checkOutput("event count", reconfig_cnt_o, monEv.cnt);
        if (done_o) begin
          checkOutput("rm_reset length", rmHigh, RMR);
          checkOutput("busy at done", busy_o, 0);
        end else begin
          checkOutput("err outputs",
                      {shutIf.request_shutdown, decouple_o, rm_reset_o}, 3'b011);
        end
      end
    end
    if (!busy_o) rmHigh = 0;
    prevErr = error_o;
  end

  initial begin
    int n;
    shutIf.in_shutdown = 1'b0;

    // Reset with the start request held high throughout.
    rst = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset outputs",
                {shutIf.request_shutdown, decouple_o, rm_reset_o, busy_o, done_o, error_o}, 0);
    checkOutput("reset count", reconfig_cnt_o, 0);
    rst = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("held start busy", busy_o, 0);
    checkOutput("held start request", shutIf.request_shutdown, 0);
    idle(2);

    // Nominal cycle: in_shutdown 3 cycles after start, pr_done 50 later.
    runCycle(2, 48, 1, 1'b0);
    idle(2);
    checkOutput("nominal count", reconfig_cnt_o, 1);

    // Minimum-latency cycle.
    runCycle(0, 0, 0, 1'b0);
    idle(1);

    // Tie cases: in_shutdown on the last REQ cycle, pr_done on the last WAIT_PR cycle.
    runCycle(SHUT_T - 1, 0, 0, 1'b0);
    idle(2);
    runCycle(0, PR_T - 1, 0, 1'b0);
    idle(2);

`ifdef DFX_SEQ_TIMEOUT_EN
    runTimeout(1'b0);
    runTimeout(1'b1);
`else
    // Without timeouts REQ and WAIT_PR wait well past the timeout values.
    runCycle(SHUT_T + 80, PR_T + 40, 0, 1'b0);
    idle(2);
    checkOutput("no error without timeouts", error_o, 0);
`endif

    // Ignored inputs, then randomised cycles.
    for (int i = 0; i < 4; i++) begin
      runCycle($urandom_range(0, 4), $urandom_range(1, 8), $urandom_range(0, 3), 1'b1);
      idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 10; i++) begin
      runCycle($urandom_range(0, 6), $urandom_range(1, 12), $urandom_range(0, 4),
               1'($urandom_range(0, 1)));
      idle($urandom_range(1, 3));
    end

    // Reset in the middle of RM_RST.
    n = cyc + 1;
    while (cyc < n + 6) applyStimulus(cyc + 1 == n, (cyc + 1) > n, (cyc + 1) == n + 3, 1'b0);
    checkOutput("rm_reset before abort", rm_reset_o, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("outputs after abort",
                {shutIf.request_shutdown, decouple_o, rm_reset_o, busy_o, done_o, error_o}, 0);
    checkOutput("count after abort", reconfig_cnt_o, 0);
    rst = 1'b0;
    modelCnt = 0;
    idle(2);

    // Counter wrap: 256 completed cycles bring the count back to 0.
    for (int i = 0; i < 256; i++) begin
      runCycle($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      idle(1);
    end
    checkOutput("count after wrap", reconfig_cnt_o, 0);

    idle(4);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
